// File: rtl/approx_mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Mode 1 drops partial-product columns below TRUNC for a cheaper approximate result.
module approx_mul_seq #(
  parameter int WIDTH = 10,
  parameter int TRUNC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] O
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [PW-1:0] MASK = {PW{1'b1}} << TRUNC;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    pp_raw;
  logic [PW-1:0]    pp;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid)    state_n = BUSY;
      BUSY:    if (cnt == LAST) state_n = DONE;
      DONE:    if (out_ready)   state_n = IDLE;
      default:                  state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): in_ready  = 1'b1;
      (state == DONE): out_valid = 1'b1;
      default:         ;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;

  // Masked partial product never exceeds the exact one, so acc cannot wrap.
  always_comb begin
    pp_raw = {{WIDTH{1'b0}}, a_q} << cnt;
    pp     = mode_q ? (pp_raw & MASK) : pp_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      mode_q <= mode;
      cnt    <= '0;
      acc    <= '0;
    end else if (state == BUSY) begin
      if (b_q[cnt]) acc <= acc + pp;
      cnt <= cnt + CW'(1);
    end
  end

  assign O = acc;

endmodule

// File: tb/tb_approx_mul_seq.sv
// Scoreboard bench for approx_mul_seq: cycle-level handshake model
// plus arithmetic reference for exact and truncated products.
module tb_approx_mul_seq;

  localparam int WIDTH = 10;
  localparam int TRUNC = 4;
  localparam int PW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic          mode = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] o_out;

  logic rnd_en  = 1'b0;
  logic rnd_bit = 1'b1;
  logic dir_rdy = 1'b1;

  assign out_ready = rnd_en ? rnd_bit : dir_rdy;

  int n_chk  = 0;
  int n_fail = 0;

  approx_mul_seq #(.WIDTH(WIDTH), .TRUNC(TRUNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .O         (o_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  function automatic longint unsigned ref_mul(
    input longint unsigned a,
    input longint unsigned b,
    input bit m
  );
    longint unsigned s;
    longint unsigned p;
    if (!m) return a * b;
    s = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) begin
        p = a << i;
        s += (p >> TRUNC) << TRUNC;
      end
    end
    return s;
  endfunction

  task automatic check(input string nm, input longint unsigned act,
                       input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle model: 0 idle, 1 busy, 2 done
  longint unsigned sb[$];
  int   m_st   = 0;
  int   m_k    = 0;
  bit   m_live = 0;
  bit   m_zero = 0;

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", in_ready, m_st == 0);
      check("out_valid", out_valid, m_st == 2);
      if (m_st == 2) begin
        if (sb.size() == 0) check("sb_empty_done", 1, 0);
        else                check("O", o_out, sb[0]);
      end
      if (m_zero) check("O_after_rst", o_out, 0);
    end
    m_zero = 0;
    if (rst) begin
      m_live = 1;
      m_st   = 0;
      sb.delete();
      m_zero = 1;
    end else if (m_live) begin
      case (m_st)
        0: if (in_valid) begin
          sb.push_back(ref_mul(a_in, b_in, mode));
          m_st = 1;
          m_k  = 0;
        end
        1: begin
          m_k++;
          if (m_k == WIDTH) m_st = 2;
        end
        default: if (out_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          m_st = 0;
        end
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input longint unsigned a, input longint unsigned b,
                       input bit m);
    int n;
    bit acc;
    n = 0;
    a_in = WIDTH'(a);
    b_in = WIDTH'(b);
    mode = m;
    in_valid = 1'b1;
    forever begin
      acc = in_ready && !rst;
      step(1);
      n++;
      if (acc) break;
      if (n > 200) begin
        check("issue_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready) begin
      step(1);
      n++;
      if (n > 500) begin
        check("idle_timeout", 1, 0);
        break;
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);

    dir_rdy = 1'b1;
    issue(1023, 1023, 0);
    wait_idle();
    issue(15, 15, 1);
    wait_idle();
    issue(15, 15, 0);
    wait_idle();
    issue(0, 1023, 0);
    wait_idle();
    issue(1, 1, 0);
    wait_idle();
    issue(1, 1, 1);
    wait_idle();

    // backpressure with stray in_valid pulses
    dir_rdy = 1'b0;
    issue(1000, 999, 1);
    a_in = 10'd3;
    b_in = 10'd5;
    mode = 1'b0;
    in_valid = 1'b1;
    step(2);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      step(1);
      n++;
    end
    check("bp_reach_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a_in = WIDTH'(i + 100);
      step(1);
    end
    in_valid = 1'b0;
    dir_rdy = 1'b1;
    wait_idle();

    // reset aborts an operation mid-flight
    issue(500, 600, 0);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    issue(7, 9, 0);
    wait_idle();

    // reset coincident with in_valid is not an acceptance
    a_in = 10'd11;
    b_in = 10'd13;
    in_valid = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    in_valid = 1'b0;
    step(2);

    rnd_en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      longint unsigned ra;
      longint unsigned rb;
      ra = $urandom_range(0, (1 << WIDTH) - 1);
      rb = $urandom_range(0, (1 << WIDTH) - 1);
      if (k % 50 == 0) ra = 0;
      if (k % 50 == 1) rb = (1 << WIDTH) - 1;
      issue(ra, rb, $urandom_range(0, 1) != 0);
      step($urandom_range(0, 3));
    end
    wait_idle();
    rnd_en = 1'b0;
    step(2);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mul_seq.md
APPROX_MUL_SEQ -- requirements
Module: approx_mul_seq

Interface
REQ-001 Parameter WIDTH, default 10: unsigned operand width; legal range 2..32.
REQ-002 Parameter TRUNC, default 4: number of low product columns dropped in approximate mode; legal range 0..2*WIDTH-1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands and mode are presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 A  input  WIDTH  unsigned multiplicand.
REQ-008 B  input  WIDTH  unsigned multiplier.
REQ-009 mode  input  1  0 = exact product, 1 = truncated approximate product.
REQ-010 out_valid  output  1  result O is valid.
REQ-011 out_ready  input  1  consumer accepts O.
REQ-012 O  output  2*WIDTH  product, unsigned.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 On an edge with in_valid=1 in IDLE, the block SHALL latch A, B and mode, clear the accumulator and the bit counter, and enter BUSY.
REQ-016 in_valid in BUSY or DONE SHALL be ignored; the inputs SHALL not affect the operation in progress.
REQ-017 Each BUSY cycle SHALL process latched B bit i, i = counter, 0..WIDTH-1, in ascending order.
REQ-018 The processing step SHALL be: if B[i]=1, add partial product PP_i = A<<i to the 2*WIDTH-bit accumulator.
REQ-019 In mode 1, PP_i bits below column TRUNC SHALL be forced to 0 before the add; in mode 0, PP_i SHALL be unmasked.
REQ-020 With TRUNC=0, mode 1 SHALL equal mode 0.
REQ-021 The accumulator SHALL be 2*WIDTH bits and SHALL never overflow, because the masked sum never exceeds the exact product.
REQ-022 After processing i=WIDTH-1 the block SHALL enter DONE; out_valid SHALL rise exactly WIDTH cycles after the acceptance edge.
REQ-023 Latency SHALL be fixed and independent of operand values, including zero operands.
REQ-024 In DONE, O SHALL hold the final accumulator value stable until the handshake.
REQ-025 On an edge with out_valid=1 and out_ready=1, the block SHALL return to IDLE.
REQ-026 A new operation SHALL not be accepted in the same cycle as the output handshake; the minimum issue interval is WIDTH+2 cycles.
REQ-027 O outside DONE SHALL hold the last accumulator value; consumers SHALL ignore it.

Reset
REQ-028 While rst=1 on an edge, the FSM SHALL enter IDLE.
REQ-029 While rst=1 on an edge, the accumulator, O, the counter and the latched operands SHALL clear to 0, giving in_ready=1, out_valid=0 and O=0 after the edge.
REQ-030 rst SHALL take priority over every handshake.
REQ-031 rst asserted in BUSY or DONE SHALL abort the operation with no result presented.
REQ-032 rst coincident with in_valid SHALL not accept the operands.

Verification
REQ-033 WIDTH=10, mode=0, A=1023, B=1023, out_ready=1 -> out_valid high 10 cycles after acceptance, O=1046529, then in_ready=1 on the next cycle.
REQ-034 WIDTH=10, TRUNC=4, mode=1, A=15, B=15 -> O=176 (exact 225); the same operands with mode=0 -> O=225.
REQ-035 A=0, B=1023, mode=0 -> O=0 with the same 10-cycle latency; A=1, B=1 -> O=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles after out_valid -> O and out_valid stay stable; in_valid pulses with other operands during BUSY and DONE do not alter O; the operation completes on out_ready=1.
REQ-037 rst pulsed 3 cycles into BUSY -> next cycle in_ready=1, out_valid=0, O=0; the following operation A=7, B=9 yields O=63.
REQ-038 Randomised run, 1000 operations in both modes with random in_valid/out_ready gaps -> every O matches the reference model: sum over B[i]=1 of masked A<<i.
